// File: rtl/ip_uart_rx_if.sv
// cZ80 I/O bus slave port: request from the CPU side, ready/read-data return.
// Unselected slaves drive zeros so several returns can be ORed together.
interface ip_uart_rx_if;
  logic [7:0] bus_address;
  logic       bus_ioreq;
  logic       bus_write;
  logic       bus_valid;
  logic       bus_ready;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/ip_uart_rx.sv
// 8N1 UART receiver with RX FIFO on the cZ80 I/O bus (DATA at base, STATUS at base+1).
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose the parity error flag.
module ip_uart_rx #(
  parameter int         clk_freq        = 42954540,
  parameter int         uart_freq       = 115200,
  parameter logic [7:0] io_address      = 8'h10,
  parameter int         fifo_depth_log2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  ip_uart_rx_if.slave bus,
  input  logic        uart_rx
);

  localparam int DIV   = clk_freq / uart_freq;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = fifo_depth_log2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [7:0]       ADDR_DATA = io_address;
  localparam logic [7:0]       ADDR_STAT = io_address + 8'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, ff_rx;
  logic             push_p1, frm_set_p1, par_set_p1;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             ovr_err, frm_err, par_err;
  logic [7:0]       rdata_p1;
  logic             rdata_en_p1;

  // Line synchroniser; resets to the idle level so no false start is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      ff_rx   <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      ff_rx   <= rx_meta;
    end
  end

  wire bit_tick = (cnt == DIV_LAST);

  // Stage p0: frame sequencing on the synchronised line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      push_p1    <= 1'b0;
      frm_set_p1 <= 1'b0;
    end else begin
      push_p1    <= 1'b0;
      frm_set_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!ff_rx) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ff_rx ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (ff_rx) begin
              push_p1 <= 1'b1;
              state   <= S_IDLE;
            end else begin
              frm_set_p1 <= 1'b1;
              state      <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (ff_rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first; the register holds the byte until the stop bit is judged.
  always_ff @(posedge clk) begin
    if (state == S_DATA && bit_tick) shift <= {ff_rx, shift[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  // Even parity: the parity bit makes the total count of ones even.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad    <= 1'b0;
      par_set_p1 <= 1'b0;
    end else begin
      par_set_p1 <= 1'b0;
      if (state == S_PARITY && bit_tick) par_bad <= ff_rx ^ (^shift);
      if (state == S_STOP && bit_tick && ff_rx) par_set_p1 <= par_bad;
    end
  end
`else
  assign par_set_p1 = 1'b0;
`endif

  // Stage p1: FIFO and bus response
  wire sel      = bus.bus_valid & bus.bus_ioreq &
                  ((bus.bus_address == ADDR_DATA) | (bus.bus_address == ADDR_STAT));
  wire rd_data  = sel & ~bus.bus_write & (bus.bus_address == ADDR_DATA);
  wire rd_stat  = sel & ~bus.bus_write & (bus.bus_address == ADDR_STAT);
  wire wr_stat  = sel &  bus.bus_write & (bus.bus_address == ADDR_STAT);
  wire empty    = (count == '0);
  wire full     = (count == (AW+1)'(DEPTH));
  wire pop      = rd_data & ~empty;
  wire push_ok  = push_p1 & (~full | pop);
  wire ovr_set  = push_p1 & full & ~pop;
  wire flush    = wr_stat & bus.bus_wdata[7];

  wire [7:0] status = {4'b0000, par_err, frm_err, ovr_err, ~empty};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovr_err     <= 1'b0;
      frm_err     <= 1'b0;
      rdata_p1    <= 8'h00;
      rdata_en_p1 <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
      ovr_err <= ovr_set    | (ovr_err & ~(wr_stat & bus.bus_wdata[1]));
      frm_err <= frm_set_p1 | (frm_err & ~(wr_stat & bus.bus_wdata[2]));
      rdata_en_p1 <= rd_data | rd_stat;
      if (rd_data)      rdata_p1 <= empty ? 8'h00 : mem[rd_ptr];
      else if (rd_stat) rdata_p1 <= status;
      else              rdata_p1 <= 8'h00;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_err <= 1'b0;
    else          par_err <= par_set_p1 | (par_err & ~(wr_stat & bus.bus_wdata[3]));
  end

  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.bus_wdata[6:4], bus.bus_wdata[0]};
`else
  assign par_err = 1'b0;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.bus_wdata[6:3], bus.bus_wdata[0], par_set_p1};
`endif

  assign bus.bus_ready    = sel;
  assign bus.bus_rdata    = rdata_p1;
  assign bus.bus_rdata_en = rdata_en_p1;

endmodule

// File: tb/tb_ip_uart_rx.sv
// Scoreboard bench for ip_uart_rx: randomized serial frames against a queue-based
// model of the receive FIFO and status flags; a monitor checks every read strobe.
module tb_ip_uart_rx;

  localparam int         CLK_FREQ  = 42954540;
  localparam int         UART_FREQ = 1342329;
  localparam int         BIT       = CLK_FREQ / UART_FREQ;
  localparam logic [7:0] BASE      = 8'h10;
  localparam int         DEPTH     = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rx = 1'b1;

  ip_uart_rx_if bus_if ();

  ip_uart_rx #(
    .clk_freq(CLK_FREQ), .uart_freq(UART_FREQ),
    .io_address(BASE), .fifo_depth_log2(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if.slave), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] m_fifo [$];
  logic       m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;

  function automatic logic [7:0] m_status();
    return {4'b0000, m_par, m_frm, m_ovr, (m_fifo.size() != 0)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_if.bus_rdata_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe: unexpected rdata_en, rdata %02h", bus_if.bus_rdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus_if.bus_rdata !== e) begin
            errors++;
            $display("FAIL rdata: got %02h expected %02h", bus_if.bus_rdata, e);
          end
        end
      end else if (bus_if.bus_rdata !== 8'h00 || bus_if.bus_rdata_en !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL idle_rdata: got %02h en %b expected 00 en 0",
                 bus_if.bus_rdata, bus_if.bus_rdata_en);
      end
    end
  end

  task automatic idle_bus();
    bus_if.bus_valid   = 1'b0;
    bus_if.bus_ioreq   = 1'b0;
    bus_if.bus_write   = 1'b0;
    bus_if.bus_address = 8'h00;
    bus_if.bus_wdata   = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] addr);
    logic sel;
    sel = (addr == BASE) || (addr == BASE + 8'd1);
    @(negedge clk);
    bus_if.bus_valid = 1'b1; bus_if.bus_ioreq = 1'b1; bus_if.bus_write = 1'b0;
    bus_if.bus_address = addr;
    #1;
    check("ready_rd", {7'b0, bus_if.bus_ready}, {7'b0, sel});
    if (addr == BASE) begin
      if (m_fifo.size() == 0) exp_q.push_back(8'h00);
      else                    exp_q.push_back(m_fifo.pop_front());
    end else if (addr == BASE + 8'd1) begin
      exp_q.push_back(m_status());
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    logic sel;
    sel = (addr == BASE) || (addr == BASE + 8'd1);
    @(negedge clk);
    bus_if.bus_valid = 1'b1; bus_if.bus_ioreq = 1'b1; bus_if.bus_write = 1'b1;
    bus_if.bus_address = addr; bus_if.bus_wdata = data;
    #1;
    check("ready_wr", {7'b0, bus_if.bus_ready}, {7'b0, sel});
    if (addr == BASE + 8'd1) begin
      if (data[1]) m_ovr = 1'b0;
      if (data[2]) m_frm = 1'b0;
`ifdef UART_RX_PARITY_EN
      if (data[3]) m_par = 1'b0;
`endif
      if (data[7]) m_fifo.delete();
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic hold_line(input logic level, input int cycles);
    uart_rx = level;
    repeat (cycles) @(negedge clk);
  endtask

  // A bad stop bit leaves the line low for a further three bit times.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good);
    @(negedge clk);
    hold_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold_line((^d) ^ ~par_good, BIT);
`endif
    hold_line(stop, BIT);
    if (!stop) begin
      hold_line(1'b0, 3 * BIT);
      m_frm = 1'b1;
    end else begin
`ifdef UART_RX_PARITY_EN
      if (!par_good) m_par = 1'b1;
`endif
      if (m_fifo.size() == DEPTH) m_ovr = 1'b1;
      else                        m_fifo.push_back(d);
    end
    hold_line(1'b1, 2 * BIT);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] r;
    idle_bus();
    repeat (5) @(negedge clk);
    check("reset_rdata", bus_if.bus_rdata, 8'h00);
    check("reset_en", {7'b0, bus_if.bus_rdata_en}, 8'h00);
    check("reset_ready", {7'b0, bus_if.bus_ready}, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame's data bits.
    hold_line(1'b0, BIT);
    hold_line(1'b1, BIT);
    hold_line(1'b0, BIT / 2);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("midrst_rdata", bus_if.bus_rdata, 8'h00);
    check("midrst_en", {7'b0, bus_if.bus_rdata_en}, 8'h00);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    hold_line(1'b1, 2 * BIT);
    bus_read(BASE + 8'd1);
    send_frame(8'h3C, 1'b1, 1'b1);
    bus_read(BASE);

    // Single byte, status before and after.
    send_frame(8'hA5, 1'b1, 1'b1);
    bus_read(BASE + 8'd1);
    bus_read(BASE);
    @(negedge clk);
    check("strobe_1cyc", {7'b0, bus_if.bus_rdata_en}, 8'h00);
    bus_read(BASE + 8'd1);

    // Overflow: 17 bytes, 16 kept.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b1);
    bus_read(BASE + 8'd1);
    for (int i = 0; i < 16; i++) bus_read(BASE);
    bus_write(BASE + 8'd1, 8'h02);
    bus_read(BASE + 8'd1);

    // Framing error followed by a held-low line.
    send_frame(8'h77, 1'b0, 1'b1);
    bus_read(BASE + 8'd1);
    bus_read(BASE);
    bus_write(BASE + 8'd1, 8'h04);
    bus_read(BASE + 8'd1);

    // Short glitch shorter than half a bit.
    hold_line(1'b0, BIT / 4);
    hold_line(1'b1, 2 * BIT);
    bus_read(BASE + 8'd1);
    bus_read(BASE);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0);
    bus_read(BASE + 8'd1);
    bus_read(BASE);
    bus_write(BASE + 8'd1, 8'h08);
    bus_read(BASE + 8'd1);
`endif

    // Write to DATA is accepted and ignored; foreign addresses are not acknowledged.
    bus_write(BASE, 8'hFF);
    bus_read(8'h20);
    for (int i = 0; i < 6; i++) bus_read(8'($urandom_range(0, 31)));

    // Random traffic with interleaved reads, bad stop bits and a flush.
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom);
      send_frame(r, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) bus_read(BASE);
      if ($urandom_range(0, 3) == 0) bus_read(BASE + 8'd1);
    end
    bus_read(BASE + 8'd1);
    n = m_fifo.size();
    if (n > 2) begin
      bus_read(BASE);
      bus_write(BASE + 8'd1, 8'h80);
      bus_read(BASE + 8'd1);
    end
    n = m_fifo.size();
    for (int i = 0; i < n; i++) bus_read(BASE);
    bus_write(BASE + 8'd1, 8'h0E);
    bus_read(BASE + 8'd1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
